// File: rtl/or8_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xiphos_arb_pkg
//  Purpose  : Shared types, constants and the rotating-priority pick helper
//             for the 8-way round-robin arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package xiphos_arb_pkg;

   localparam int ARB_N   = 8;
   localparam int ARB_IDW = 3;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   // Scan ptr, ptr+1, ... (mod 8); return {found, index of first set bit}.
   function automatic logic [ARB_IDW:0] rr_pick(input logic [ARB_N-1:0]   req,
                                                input logic [ARB_IDW-1:0] ptr);
      logic               found;
      logic [ARB_IDW-1:0] idx;
      logic [ARB_IDW-1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < ARB_N; k++) begin
         cand = ptr + ARB_IDW'(k);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/or8_rr_arbiter_or8way.sv
`default_nettype none
// ============================================================================
//  Module   : OR8Way
//  Purpose  : 8-input OR reduction; flags that at least one request is set.
//  Revision : 1.0  initial release
// ============================================================================
module OR8Way (
   input  logic [7:0] X,
   output logic       OUT
);

   assign OUT = |X;

endmodule
`default_nettype wire

// File: rtl/or8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : or8_rr_arbiter
//  Purpose  : 8-requester round-robin arbiter with registered one-hot grant,
//             hold-until-release ownership and back-to-back handover.
//  Options  : define ARB_TIMEOUT_EN to revoke a grant held for HOLD_MAX
//             consecutive cycles (TIMEOUT pulses); otherwise TIMEOUT is 0.
//  Revision : 1.0  initial release
// ============================================================================
module or8_rr_arbiter
   import xiphos_arb_pkg::*;
#(
   parameter int N        = ARB_N,
   parameter int HOLD_MAX = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [N-1:0]       REQ,
   output logic [N-1:0]       GNT,
   output logic [ARB_IDW-1:0] GNT_ID,
   output logic               BUSY,
   output logic               TIMEOUT
);

   // Elaboration-time guard: the OR8Way front end fixes the width at 8.
   if (N != ARB_N || HOLD_MAX < 2) begin : g_param_check
      $error("or8_rr_arbiter: N must be 8 and HOLD_MAX must be >= 2");
   end

   arb_state_t         r_state,  w_state_nxt;
   logic [N-1:0]       r_gnt,    w_gnt_nxt;
   logic [ARB_IDW-1:0] r_gnt_id, w_gnt_id_nxt;
   logic [ARB_IDW-1:0] r_ptr,    w_ptr_nxt;
   logic               r_busy;
   logic               w_any_req;
   logic               w_found;
   logic [ARB_IDW-1:0] w_win;
   logic               w_owner_req;
   logic               w_expire;

   OR8Way u_or8way (
      .X   (REQ),
      .OUT (w_any_req)
   );

   // The current owner is masked out so a release or revoke hands over to
   // someone else; in IDLE r_gnt is zero so the mask is a no-op.
   assign {w_found, w_win} = rr_pick(REQ & ~r_gnt, r_ptr);
   assign w_owner_req      = REQ[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
   localparam int c_hcw = $clog2(HOLD_MAX);

   logic [c_hcw-1:0] r_hc;
   logic             r_timeout;
   logic             w_hc_clr;

   assign w_expire = (r_state == ARB_GRANT) && w_owner_req &&
                     (r_hc == c_hcw'(HOLD_MAX - 1));
   // Every fresh grant (including re-grant after a revoke) restarts the count.
   assign w_hc_clr = (r_state == ARB_IDLE) || !w_owner_req || w_expire;

   // Hold counter and one-cycle revoke pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_hc      <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_expire;
         if (w_hc_clr)
            r_hc <= '0;
         else
            r_hc <= r_hc + c_hcw'(1);
      end
   end

   assign TIMEOUT = r_timeout;
`else
   assign w_expire = 1'b0;
   assign TIMEOUT  = 1'b0;
`endif

   // State, grant, owner index, priority pointer and busy registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ARB_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_ptr    <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_ptr    <= w_ptr_nxt;
         r_busy   <= |w_gnt_nxt;
      end
   end

   // Next-state: grant from IDLE, hold, hand over, re-grant or go idle.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_ptr_nxt    = r_ptr;
      case (r_state)
         ARB_IDLE: begin
            if (w_any_req) begin
               w_state_nxt  = ARB_GRANT;
               w_gnt_nxt    = N'(1) << w_win;
               w_gnt_id_nxt = w_win;
               w_ptr_nxt    = w_win + ARB_IDW'(1);
            end
         end
         ARB_GRANT: begin
            if (!w_owner_req || w_expire) begin
               if (w_found) begin
                  w_gnt_nxt    = N'(1) << w_win;
                  w_gnt_id_nxt = w_win;
                  w_ptr_nxt    = w_win + ARB_IDW'(1);
               end else if (w_expire) begin
                  // Nobody else waiting: the revoked owner keeps the resource.
                  w_ptr_nxt    = r_gnt_id + ARB_IDW'(1);
               end else begin
                  w_state_nxt  = ARB_IDLE;
                  w_gnt_nxt    = '0;
               end
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   assign GNT    = r_gnt;
   assign GNT_ID = r_gnt_id;
   assign BUSY   = r_busy;

endmodule
`default_nettype wire
